instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit.
- Owns the program counter and fetches 16-bit instruction words from program memory over a req/ack handshake.
- Holds fetched words in a small prefetch buffer and presents the head word, with its address, to the control unit.
- Applies jump redirects and flushes on request; stops fetching while the CPU is halted.

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory fetch FSM and prefetch FIFO for the control unit.
// Optional request watchdog and sticky fetch_err port are enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PF_DEPTH = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  input  logic              instr_take,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
`ifdef FETCH_TIMEOUT_EN
  output logic              fetch_err,
`endif
  output logic [ADDR_W-1:0] pc_out
);

  localparam int unsigned PTR_W = $clog2(PF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_buf_data [PF_DEPTH];
  logic [ADDR_W-1:0] r_buf_pc   [PF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_tmo;

  assign w_push = (r_state == StReq) && mem_ack && !jmp_en;
  assign w_pop  = instr_take && (r_count != '0) && !jmp_en;
  assign w_full = (r_count == CNT_W'(PF_DEPTH));

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_fetch_err;

  assign w_tmo = (r_state != StIdle) && !mem_ack && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state == StIdle || mem_ack || w_tmo) r_tmo_cnt <= '0;
      else                                       r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (w_tmo) r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT;
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < PF_DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      if (jmp_en) begin
        r_pc     <= jmp_addr;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_buf_data[r_wr_ptr] <= mem_rdata;
          r_buf_pc[r_wr_ptr]   <= r_mem_addr;
          r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
          r_pc                 <= r_pc + ADDR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end

      unique case (r_state)
        StIdle: begin
          // Issuing on a jump cycle would fetch the stale pc, so wait one cycle.
          if (!jmp_en && !halted && !w_full) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= StReq;
          end
        end
        StReq: begin
          if (mem_ack || w_tmo) begin
            r_mem_rd <= 1'b0;
            r_state  <= StIdle;
          end else if (jmp_en) begin
            r_state <= StDrop;
          end
        end
        StDrop: begin
          if (mem_ack || w_tmo) begin
            r_mem_rd <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: begin
          r_mem_rd <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign instr_out   = r_buf_data[r_rd_ptr];
  assign instr_pc    = r_buf_pc[r_rd_ptr];
  assign instr_valid = (r_count != '0);
  assign pc_out      = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory responder.
// Covers reset, prefetch fill, jump/drop, PC wrap, halt and (with FETCH_TIMEOUT_EN) the watchdog.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halted = 1'b0;
  logic        instr_take = 1'b0;
  logic        jmp_en = 1'b0;
  logic [15:0] jmp_addr = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [15:0] pc_out;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 0;
  logic [15:0] issued [$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .halted     (halted),
    .instr_take (instr_take),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
`ifdef FETCH_TIMEOUT_EN
    .fetch_err  (fetch_err),
`endif
    .pc_out     (pc_out)
  );

  // Memory image: byte-swapped address xor 0x1234.
  function automatic logic [15:0] memw(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  // Responder works on the falling edge; logs every new request address.
  initial begin
    int   wait_cnt;
    logic last_rd;
    wait_cnt = 0;
    last_rd  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd && !last_rd) issued.push_back(mem_addr);
      last_rd = mem_rd;
      if (mem_rd && !mem_ack) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = memw(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        if (!mem_rd) wait_cnt = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int bound);
    for (int i = 0; i < bound && !instr_valid; i++) tick();
    check_eq(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [15:0] addr, input int bound);
    for (int i = 0; i < bound && !(mem_rd && mem_addr == addr); i++) tick();
    check_eq(tag, {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, addr});
  endtask

  initial begin
    int n_hi;

    // Reset held over several edges
    tick(3);
    check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr_out", {16'd0, instr_out}, 32'h0);
    check_eq("rst_instr_pc", {16'd0, instr_pc}, 32'h0);
    check_eq("rst_pc_out", {16'd0, pc_out}, 32'h0);
`ifdef FETCH_TIMEOUT_EN
    check_eq("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
`endif

    // First fetch after release
    reset = 1'b1;
    tick();
    check_eq("first_rd", {31'd0, mem_rd}, 32'd1);
    check_eq("first_addr", {16'd0, mem_addr}, 32'h0000);
    tick();
    check_eq("first_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("first_out", {16'd0, instr_out}, 32'h1234);
    check_eq("first_pc", {16'd0, instr_pc}, 32'h0000);
    check_eq("first_pc_out", {16'd0, pc_out}, 32'h0001);

    // Buffer fills at two entries and fetching stops
    tick(8);
    check_eq("full_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("full_pc_out", {16'd0, pc_out}, 32'h0002);
    check_eq("full_n_issued", issued.size(), 32'd2);
    check_eq("full_issue1", {16'd0, issued[1]}, 32'h0001);
    check_eq("full_head_pc", {16'd0, instr_pc}, 32'h0000);

    instr_take = 1'b1;
    tick();
    instr_take = 1'b0;
    check_eq("take_out", {16'd0, instr_out}, 32'h1334);
    check_eq("take_pc", {16'd0, instr_pc}, 32'h0001);
    for (int i = 0; i < 10 && issued.size() < 3; i++) tick();
    check_eq("take_n_issued", issued.size(), 32'd3);
    check_eq("take_issue2", {16'd0, issued[2]}, 32'h0002);
    tick(6);

    // Jump while the request to 0x0003 is outstanding
    mem_lat = 4;
    instr_take = 1'b1;
    tick();
    instr_take = 1'b0;
    wait_req("drop_req3", 16'h0003, 10);
    jmp_en   = 1'b1;
    jmp_addr = 16'h0040;
    tick();
    jmp_en  = 1'b0;
    mem_lat = 0;
    check_eq("jmp_flush", {31'd0, instr_valid}, 32'd0);
    check_eq("jmp_pc_out", {16'd0, pc_out}, 32'h0040);
    check_eq("drop_hold", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0003});
    wait_valid("drop_valid", 30);
    check_eq("drop_head_pc", {16'd0, instr_pc}, 32'h0040);
    check_eq("drop_head_out", {16'd0, instr_out}, 32'h5234);
    check_eq("drop_issue", {16'd0, issued[4]}, 32'h0040);
    tick(12);

    // Jump to 0xFFFF with a same-cycle take on a full buffer, then wrap
    instr_take = 1'b1;
    jmp_en     = 1'b1;
    jmp_addr   = 16'hFFFF;
    tick();
    jmp_en = 1'b0;
    issued.delete();
    check_eq("wrap_flush", {31'd0, instr_valid}, 32'd0);
    check_eq("wrap_pc_out", {16'd0, pc_out}, 32'hFFFF);
    wait_valid("wrap_valid0", 10);
    check_eq("wrap_pc0", {16'd0, instr_pc}, 32'hFFFF);
    check_eq("wrap_out0", {16'd0, instr_out}, 32'hEDCB);
    tick();
    wait_valid("wrap_valid1", 10);
    check_eq("wrap_pc1", {16'd0, instr_pc}, 32'h0000);
    check_eq("wrap_out1", {16'd0, instr_out}, 32'h1234);
    check_eq("wrap_n_issued", {31'd0, issued.size() >= 2}, 32'd1);
    check_eq("wrap_issue0", {16'd0, issued[0]}, 32'hFFFF);
    check_eq("wrap_issue1", {16'd0, issued[1]}, 32'h0000);

    // Halt while a request to 0x0100 is in flight
    instr_take = 1'b0;
    jmp_en     = 1'b1;
    jmp_addr   = 16'h0100;
    tick();
    jmp_en = 1'b0;
    issued.delete();
    mem_lat = 3;
    wait_req("halt_req", 16'h0100, 20);
    halted = 1'b1;
    tick(12);
    check_eq("halt_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("halt_head_pc", {16'd0, instr_pc}, 32'h0100);
    check_eq("halt_head_out", {16'd0, instr_out}, 32'h1235);
    check_eq("halt_pc_out", {16'd0, pc_out}, 32'h0101);
    check_eq("halt_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("halt_n_issued", issued.size(), 32'd1);
    halted = 1'b0;
    for (int i = 0; i < 10 && issued.size() < 2; i++) tick();
    check_eq("resume_n_issued", issued.size(), 32'd2);
    check_eq("resume_issue", {16'd0, issued[1]}, 32'h0101);
    tick(20);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: request drops after 15 cycles and is retried
    mem_lat  = 1000000;
    jmp_en   = 1'b1;
    jmp_addr = 16'h0200;
    tick();
    jmp_en = 1'b0;
    wait_req("tmo_req", 16'h0200, 10);
    n_hi = 0;
    for (int i = 0; i < 40 && mem_rd; i++) begin
      n_hi++;
      tick();
    end
    check_eq("tmo_rd_cycles", n_hi, 32'd15);
    check_eq("tmo_rd_low", {31'd0, mem_rd}, 32'd0);
    check_eq("tmo_err", {31'd0, fetch_err}, 32'd1);
    tick();
    check_eq("tmo_retry", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0200});
    check_eq("tmo_pc_out", {16'd0, pc_out}, 32'h0200);
`else
    n_hi = 0;
    check_eq("final_mem_rd", {31'd0, mem_rd}, {31'd0, n_hi[0]});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
